// File: rtl/minrv32_mem_arbiter.sv
// rtl/minrv32_mem_arbiter.sv - two-master round-robin arbiter for a shared memory port
// Grants hold a registered copy of the winner's request; a stalled slave is aborted after TIMEOUT waits.
module minrv32_mem_arbiter #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        m0_valid,
  input  logic        m0_instr,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wstrb,
  output logic        m0_ready,
  output logic [31:0] m0_rdata,
  output logic        m0_err,
  input  logic        m1_valid,
  input  logic        m1_instr,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wstrb,
  output logic        m1_ready,
  output logic [31:0] m1_rdata,
  output logic        m1_err,
  output logic        mem_valid,
  output logic        mem_instr,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic [1:0]  grant
);

  localparam logic [1:0]  IDLE  = 2'd0;
  localparam logic [1:0]  BUSY0 = 2'd1;
  localparam logic [1:0]  BUSY1 = 2'd2;
  localparam logic [15:0] TIMEOUT_C = 16'(TIMEOUT);
  localparam bit          TIMEOUT_EN = (TIMEOUT != 0);

  logic [1:0]  state_q, state_d;
  logic        last_q, last_d;
  logic [15:0] cnt_q, cnt_d;
  logic        instr_q, instr_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;

  logic        busy;
  logic        owner;
  logic        abort;
  logic        done;
  logic        take;
  logic        sel;
  logic [31:0] rsp_data;

  assign busy  = (state_q == BUSY0) || (state_q == BUSY1);
  assign owner = (state_q == BUSY1);
  // A real completion in the timeout cycle wins over the abort.
  assign abort = busy && !mem_ready && TIMEOUT_EN && (cnt_q == TIMEOUT_C);
  assign done  = busy && (mem_ready || abort);

  always_comb begin
    state_d = busy ? state_q : IDLE;
    last_d  = last_q;
    cnt_d   = cnt_q;
    instr_d = instr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    take    = 1'b0;
    sel     = 1'b0;
    if (!busy) begin
      if (m0_valid && m1_valid) begin
        take = 1'b1;
        sel  = ~last_q;
      end else if (m0_valid || m1_valid) begin
        take = 1'b1;
        sel  = m1_valid;
      end
    end else if (done) begin
      // The finishing master still holds valid this cycle, so only the other one may win.
      last_d = owner;
      if (owner ? m0_valid : m1_valid) begin
        take = 1'b1;
        sel  = ~owner;
      end else begin
        state_d = IDLE;
      end
    end else begin
      cnt_d = cnt_q + 16'd1;
    end
    if (take) begin
      state_d = sel ? BUSY1 : BUSY0;
      cnt_d   = 16'd0;
      instr_d = sel ? m1_instr : m0_instr;
      addr_d  = sel ? m1_addr  : m0_addr;
      wdata_d = sel ? m1_wdata : m0_wdata;
      wstrb_d = sel ? m1_wstrb : m0_wstrb;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      cnt_q   <= 16'd0;
      instr_q <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      wstrb_q <= 4'd0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      instr_q <= instr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
    end
  end

  assign rsp_data  = abort ? 32'hFFFF_FFFF : mem_rdata;

  assign m0_ready  = (state_q == BUSY0) && done;
  assign m0_err    = m0_ready && abort;
  assign m0_rdata  = (state_q == BUSY0) ? rsp_data : 32'd0;
  assign m1_ready  = (state_q == BUSY1) && done;
  assign m1_err    = m1_ready && abort;
  assign m1_rdata  = (state_q == BUSY1) ? rsp_data : 32'd0;

  assign mem_valid = busy;
  assign mem_instr = instr_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_wstrb = wstrb_q;
  assign grant     = {state_q == BUSY1, state_q == BUSY0};

endmodule

// File: tb/tb_minrv32_mem_arbiter.sv
// tb/tb_minrv32_mem_arbiter.sv - directed and randomized checks of minrv32_mem_arbiter against a transaction model
module tb_minrv32_mem_arbiter;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        resetn;
  logic        m0_valid, m0_instr, m1_valid, m1_instr;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic [3:0]  m0_wstrb, m1_wstrb;
  logic        m0_ready, m0_err, m1_ready, m1_err;
  logic [31:0] m0_rdata, m1_rdata;
  logic        mem_valid, mem_instr, mem_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;
  logic [1:0]  grant;

  int n_tests = 0;
  int n_fail  = 0;

  minrv32_mem_arbiter #(.TIMEOUT(TO)) dut (
    .clk(clk), .resetn(resetn),
    .m0_valid(m0_valid), .m0_instr(m0_instr), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_wstrb(m0_wstrb), .m0_ready(m0_ready), .m0_rdata(m0_rdata), .m0_err(m0_err),
    .m1_valid(m1_valid), .m1_instr(m1_instr), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_wstrb(m1_wstrb), .m1_ready(m1_ready), .m1_rdata(m1_rdata), .m1_err(m1_err),
    .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_ready(mem_ready), .mem_rdata(mem_rdata), .grant(grant)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: who owns the port, who was served last, how long we have waited.
  int          own, last, waited;
  logic [31:0] c_addr, c_wdata;
  logic [3:0]  c_wstrb;
  logic        c_instr;
  int          n_own, n_last, n_waited;
  logic [31:0] n_addr, n_wdata;
  logic [3:0]  n_wstrb;
  logic        n_instr;

  task grab(input int k);
    n_own    = k + 1;
    n_waited = 0;
    n_addr   = (k == 1) ? m1_addr  : m0_addr;
    n_wdata  = (k == 1) ? m1_wdata : m0_wdata;
    n_wstrb  = (k == 1) ? m1_wstrb : m0_wstrb;
    n_instr  = (k == 1) ? m1_instr : m0_instr;
  endtask

  always @(negedge clk) begin : model_cmp
    int  k;
    bit  busy, abort, done;
    if (resetn === 1'b1) begin
      busy  = (own != 0);
      k     = own - 1;
      abort = busy && !mem_ready && (TO != 0) && (waited == TO);
      done  = busy && (mem_ready || abort);
      chk("model_grant", 32'(grant), (own == 1) ? 32'd1 : (own == 2) ? 32'd2 : 32'd0);
      chk("model_mem_valid", 32'(mem_valid), 32'(busy));
      chk("model_m0_ready", 32'(m0_ready), 32'(busy && k == 0 && done));
      chk("model_m1_ready", 32'(m1_ready), 32'(busy && k == 1 && done));
      chk("model_m0_err", 32'(m0_err), 32'(busy && k == 0 && abort));
      chk("model_m1_err", 32'(m1_err), 32'(busy && k == 1 && abort));
      chk("model_m0_rdata", m0_rdata, (busy && k == 0) ? (abort ? 32'hFFFF_FFFF : mem_rdata) : 32'd0);
      chk("model_m1_rdata", m1_rdata, (busy && k == 1) ? (abort ? 32'hFFFF_FFFF : mem_rdata) : 32'd0);
      if (busy) begin
        chk("model_mem_addr", mem_addr, c_addr);
        chk("model_mem_wdata", mem_wdata, c_wdata);
        chk("model_mem_wstrb", 32'(mem_wstrb), 32'(c_wstrb));
        chk("model_mem_instr", 32'(mem_instr), 32'(c_instr));
      end
      n_own = own; n_last = last; n_waited = waited;
      n_addr = c_addr; n_wdata = c_wdata; n_wstrb = c_wstrb; n_instr = c_instr;
      if (!busy) begin
        if (m0_valid && m1_valid) grab(1 - last);
        else if (m0_valid || m1_valid) grab(m1_valid ? 1 : 0);
      end else if (done) begin
        n_last = k;
        if ((k == 0) ? m1_valid : m0_valid) grab(1 - k);
        else n_own = 0;
      end else begin
        n_waited = waited + 1;
      end
    end
  end

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      own = 0; last = 1; waited = 0;
      c_addr = 32'd0; c_wdata = 32'd0; c_wstrb = 4'd0; c_instr = 1'b0;
    end else begin
      own = n_own; last = n_last; waited = n_waited;
      c_addr = n_addr; c_wdata = n_wdata; c_wstrb = n_wstrb; c_instr = n_instr;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic do_reset();
    step();
    resetn = 1'b0;
    step();
    resetn = 1'b1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : stim
    bit s0, s1;
    resetn = 1'b0;
    m0_valid = 0; m0_instr = 0; m0_addr = 0; m0_wdata = 0; m0_wstrb = 0;
    m1_valid = 0; m1_instr = 0; m1_addr = 0; m1_wdata = 0; m1_wstrb = 0;
    mem_ready = 0; mem_rdata = 0;
    repeat (3) @(posedge clk);
    sample();
    chk("reset_grant", 32'(grant), 32'd0);
    chk("reset_mem_valid", 32'(mem_valid), 32'd0);
    chk("reset_mem_addr", mem_addr, 32'd0);
    chk("reset_m0_ready", 32'(m0_ready), 32'd0);
    step();
    resetn = 1'b1;

    // Single read, memory answers on the third busy cycle.
    step();
    m0_valid = 1; m0_addr = 32'h100; m0_wstrb = 4'h0; m0_instr = 0;
    sample();
    chk("read_mem_valid_idle", 32'(mem_valid), 32'd0);
    step();
    sample();
    chk("read_mem_valid_rise", 32'(mem_valid), 32'd1);
    chk("read_mem_addr", mem_addr, 32'h100);
    chk("read_grant", 32'(grant), 32'd1);
    step();
    sample();
    chk("read_no_ready_c2", 32'(m0_ready), 32'd0);
    step();
    mem_ready = 1; mem_rdata = 32'hDEADBEEF;
    sample();
    chk("read_m0_ready", 32'(m0_ready), 32'd1);
    chk("read_m0_rdata", m0_rdata, 32'hDEADBEEF);
    chk("read_m0_err", 32'(m0_err), 32'd0);
    step();
    m0_valid = 0; mem_ready = 0;
    sample();
    chk("read_idle_after", 32'(grant), 32'd0);

    // Tie after reset: master 0 first, master 1 immediately after.
    do_reset();
    m0_valid = 1; m0_addr = 32'h10; m1_valid = 1; m1_addr = 32'h20;
    step();
    mem_ready = 1;
    sample();
    chk("tie_first_grant", 32'(grant), 32'd1);
    step();
    m0_valid = 0; mem_ready = 0;
    sample();
    chk("tie_second_grant", 32'(grant), 32'd2);
    chk("tie_no_gap", 32'(mem_valid), 32'd1);
    step();
    mem_ready = 1;
    sample();
    chk("tie_m1_ready", 32'(m1_ready), 32'd1);
    step();
    m1_valid = 0; mem_ready = 0;

    // Fairness with both masters held and an always-ready memory.
    step();
    m0_valid = 1; m1_valid = 1; mem_ready = 1;
    sample();
    chk("fair_idle_ignores_ready", 32'(grant), 32'd0);
    for (int i = 0; i < 4; i++) begin
      step();
      if (i == 3) begin
        m0_valid = 0; m1_valid = 0;
      end
      sample();
      chk($sformatf("fair_grant_%0d", i), 32'(grant), (i % 2 == 0) ? 32'd1 : 32'd2);
    end
    step();
    mem_ready = 0;
    sample();
    chk("fair_idle_end", 32'(grant), 32'd0);

    // Timeout: m1 write never answered.
    step();
    m1_valid = 1; m1_addr = 32'h200; m1_wdata = 32'h1234_5678; m1_wstrb = 4'hF; mem_rdata = 32'h5555_AAAA;
    for (int c = 1; c <= 5; c++) begin
      step();
      sample();
      chk($sformatf("to_ready_c%0d", c), 32'(m1_ready), (c == 5) ? 32'd1 : 32'd0);
      if (c == 1) chk("to_mem_wstrb", 32'(mem_wstrb), 32'hF);
    end
    chk("to_m1_err", 32'(m1_err), 32'd1);
    chk("to_m1_rdata", m1_rdata, 32'hFFFF_FFFF);
    step();
    m1_valid = 0;
    sample();
    chk("to_mem_valid_drop", 32'(mem_valid), 32'd0);

    // Asynchronous reset in the second busy cycle, then a pending m1 is served.
    step();
    m0_valid = 1; m0_addr = 32'h300;
    step();
    step();
    #2;
    resetn = 0; m0_valid = 0; m1_valid = 1; m1_addr = 32'h400; m1_wstrb = 4'h0;
    #1;
    chk("rst_mem_valid", 32'(mem_valid), 32'd0);
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_m0_ready", 32'(m0_ready), 32'd0);
    step();
    resetn = 1;
    step();
    sample();
    chk("rst_m1_grant", 32'(grant), 32'd2);
    chk("rst_m1_addr", mem_addr, 32'h400);
    step();
    mem_ready = 1;
    sample();
    step();
    m1_valid = 0; mem_ready = 0;

    // Randomized traffic against the model.
    s0 = 0; s1 = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      step();
      if (s0) m0_valid = 0;
      else if (!m0_valid && $urandom_range(0, 2) == 0) begin
        m0_valid = 1; m0_addr = $urandom; m0_wdata = $urandom;
        m0_wstrb = 4'($urandom); m0_instr = 1'($urandom);
      end
      if (s1) m1_valid = 0;
      else if (!m1_valid && $urandom_range(0, 2) == 0) begin
        m1_valid = 1; m1_addr = $urandom; m1_wdata = $urandom;
        m1_wstrb = 4'($urandom); m1_instr = 1'($urandom);
      end
      mem_ready = ($urandom_range(0, 3) == 0);
      mem_rdata = $urandom;
      sample();
      s0 = m0_ready; s1 = m1_ready;
    end

    step();
    m0_valid = 0; m1_valid = 0; mem_ready = 0;
    repeat (2) step();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/minrv32_mem_arbiter.md
MINRV32_MEM_ARBITER -- requirements
Module: minrv32_mem_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 255, max BUSY cycles before abort; 0 disables timeout.
REQ-002 clk  input  1  sole clock, all state on rising edge.
REQ-003 resetn  input  1  asynchronous, active-low reset.
REQ-004 m0_valid / m1_valid  input  1  request from master 0 (CPU) / master 1 (DMA/debug).
REQ-005 m0_instr / m1_instr  input  1  request is an instruction fetch.
REQ-006 m0_addr / m1_addr  input  32  byte address.
REQ-007 m0_wdata / m1_wdata  input  32  write data.
REQ-008 m0_wstrb / m1_wstrb  input  4  byte write strobes; 0 = read.
REQ-009 m0_ready / m1_ready  output  1  one-cycle completion pulse to the master.
REQ-010 m0_rdata / m1_rdata  output  32  read data, valid only while matching ready=1.
REQ-011 m0_err / m1_err  output  1  timeout abort flag, qualified by matching ready.
REQ-012 mem_valid  output  1  request to shared memory.
REQ-013 mem_instr, mem_addr, mem_wdata, mem_wstrb  output  1/32/32/4  registered copy of granted request.
REQ-014 mem_ready  input  1  memory completion.
REQ-015 mem_rdata  input  32  memory read data.
REQ-016 grant  output  2  one-hot owner of the memory port; 0 when idle.

Function
REQ-017 The FSM SHALL have states IDLE, BUSY0, BUSY1; grant = {state==BUSY1, state==BUSY0}.
REQ-018 Master protocol: valid and payload held stable until ready; the master drops valid the cycle after ready.
REQ-019 In IDLE with exactly one mN_valid, the arbiter SHALL enter BUSYN on the next edge.
REQ-020 In IDLE with both valid, the grant SHALL go to the master not served last (round-robin).
REQ-021 On grant, mem_instr/addr/wdata/wstrb SHALL be registered from the granted master and held constant until completion.
REQ-022 mem_valid SHALL be 1 exactly in BUSY0/BUSY1, one cycle after the grant request is sampled.
REQ-023 In BUSYN, mN_ready = mem_ready and mN_rdata = mem_rdata combinationally; the other master sees ready=0, rdata=0.
REQ-024 On completion (BUSYN and mem_ready=1), the arbiter SHALL re-arbitrate that edge with master N excluded: other master valid -> BUSYother, else IDLE.
REQ-025 Back-to-back alternation SHALL have no idle cycle between the two transactions.
REQ-026 mem_ready in IDLE SHALL be ignored.
REQ-027 A 16-bit wait counter SHALL clear on grant and increment each BUSY cycle with mem_ready=0.
REQ-028 When TIMEOUT!=0 and counter==TIMEOUT with mem_ready=0, the arbiter SHALL pulse mN_ready=1, mN_err=1, mN_rdata=32'hFFFF_FFFF for one cycle, then re-arbitrate per REQ-024.
REQ-029 mem_ready=1 in the timeout cycle SHALL take precedence: normal completion, err=0.
REQ-030 The last-served pointer SHALL update on every completion or abort.
REQ-031 mN_err SHALL be 0 whenever mN_ready is 0.

Reset
REQ-032 resetn=0 SHALL immediately force: state IDLE, mem_valid=0, mem_* payload 0, grant=0, all mN_ready/mN_err 0, counter 0, last-served=1 (master 0 wins first tie).
REQ-033 Reset mid-transaction SHALL abandon the transfer without issuing ready to any master.

Verification
REQ-034 Single read: m0_valid=1, addr=0x100, wstrb=0; mem_ready on 3rd BUSY cycle with rdata=0xDEADBEEF -> mem_valid rises 1 cycle after request, m0_ready=1 with m0_rdata=0xDEADBEEF, err=0.
REQ-035 Tie after reset: m0 and m1 valid together -> grant=01 first, grant=10 on the edge after m0 completion, no idle gap.
REQ-036 Fairness: both held continuously for 4 transfers, mem_ready=1 each BUSY cycle -> grants 01,10,01,10.
REQ-037 Timeout: TIMEOUT=4, m1 write 0x200 wstrb=4'hF, mem_ready never -> m1_ready=m1_err=1 after 4 BUSY cycles, m1_rdata=0xFFFFFFFF, mem_valid drops.
REQ-038 Reset: resetn pulled low in 2nd BUSY0 cycle -> mem_valid=0, grant=0 asynchronously, no m0_ready; after release, pending m1 served first only if m0 idle.
REQ-039 Stability: random mem_ready delays 0-10 -> mem_addr/wdata/wstrb unchanged from grant to completion; grant always one-hot or zero.
